disp_scan_ctrl: RTL

//   Upstream feeder for the calculator's 7-segment decoder. Takes a binary result, converts it
//   to BCD sequentially (shift-add-3), and time-multiplexes the digits onto one shared decoder.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/disp_scan_ctrl_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 57 +++++
 rtl/disp_scan_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller.
package disp_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Power-on image: digit0 shows "0", every other digit blank.
    localparam logic [31:0] RESET_DIGITS = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    function automatic longint unsigned pow10_minus1(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Load/status/display bundle between the result source and the scan controller.
interface disp_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
);
    logic [BIN_W-1:0]      bin_val;
    logic                  load;
    logic                  busy;
    logic                  ovf;
    logic [3:0]            disp_num;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output bin_val, load,
        input  busy, ovf, disp_num, an
    );

    modport slave (
        input  bin_val, load,
        output busy, ovf, disp_num, an
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq #(
    parameter int BIN_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [BIN_W-1:0]        i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [BCD_W-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // High in the cycle whose closing edge performs the final shift.
    assign o_done = r_busy && (r_cnt == CNT_W'(BIN_W - 1));
    assign o_busy = r_busy;
    assign o_bcd  = r_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_bcd  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_bin  <= i_bin;
            r_bcd  <= '0;
        end else if (r_busy) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Binary result to multiplexed 7-segment digit codes with leading-zero blanking.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input logic             clk,
    input logic             rst,
    disp_scan_ctrl_if.slave bus
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam longint unsigned POW_M1 = pow10_minus1(NUM_DIGITS);
    localparam longint unsigned BIN_MAX = (64'd1 << BIN_W) - 64'd1;
    // Saturate so an unreachable limit can never flag overflow.
    localparam logic [BIN_W-1:0] THR =
        BIN_W'((POW_M1 > BIN_MAX) ? BIN_MAX : POW_M1);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_ovf;
    logic                  r_ovf_pend;
    logic [BCD_W-1:0]      r_dig;
    logic [SCAN_W-1:0]     r_scan;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [3:0]            r_disp_num;

    logic                  w_start;
    logic                  w_eng_busy;
    logic                  w_eng_done;
    logic [BCD_W-1:0]      w_eng_bcd;
    logic [BCD_W-1:0]      w_blanked;
    logic                  w_lead;
    logic                  w_scan_tc;
    logic [IDX_W-1:0]      w_idx_nxt;

    assign w_start = (r_state == IDLE) && bus.load;

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_bin   (bus.bin_val),
        .o_busy  (w_eng_busy),
        .o_done  (w_eng_done),
        .o_bcd   (w_eng_bcd)
    );

    always_comb begin
        w_blanked = w_eng_bcd;
        w_lead    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (w_eng_bcd[4*i +: 4] == 4'd0)) begin
                w_blanked[4*i +: 4] = BLANK_CODE;
            end else begin
                w_lead = 1'b0;
            end
        end
        if (r_ovf_pend) begin
            w_blanked = {NUM_DIGITS{BLANK_CODE}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_dig      <= RESET_DIGITS[BCD_W-1:0];
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_ovf_pend <= (bus.bin_val > THR);
                        r_busy     <= 1'b1;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    if (w_eng_done || !w_eng_busy) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_dig   <= w_blanked;
                    r_ovf   <= r_ovf_pend;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_scan_tc = (r_scan == SCAN_W'(REFRESH_DIV - 1));

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_scan_tc) begin
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                w_idx_nxt = '0;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    // Anode and data both registered from the next index: no skew between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan     <= '0;
            r_idx      <= '0;
            r_an       <= ~NUM_DIGITS'(1);
            r_disp_num <= 4'h0;
        end else begin
            r_scan     <= w_scan_tc ? '0 : r_scan + 1'b1;
            r_idx      <= w_idx_nxt;
            r_an       <= ~(NUM_DIGITS'(1) << w_idx_nxt);
            r_disp_num <= r_dig[{w_idx_nxt, 2'b00} +: 4];
        end
    end

    assign bus.busy     = r_busy;
    assign bus.ovf      = r_ovf;
    assign bus.an       = r_an;
    assign bus.disp_num = r_disp_num;
endmodule
